checkpoint_seq_monitor: RTL and testbench

//  Parametrised checkpoint sequencer for the user-project pad bus.
//  - Watches a CHK_W-bit checkbits bus (e.g. mprj_io[31:16]) for an ordered list of up to NUM_CHK signature values.
//  - Reports start, per-step progress, pass, or a fail code: per-step timeout, out-of-order signature, bad config.
//  - Replaces ad-hoc two-value waits in benches; also synthesisable as an on-chip self-check / debug monitor.

---
 rtl/checkpoint_seq_monitor.sv | 198 +++++++++++++++++++
 tb/tb_checkpoint_seq_monitor.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checkpoint_seq_monitor.sv
// checkpoint_seq_monitor
//   Watches an asynchronous checkbits bus for an ordered list of signature
//   values and reports start, per-step progress, pass, or a failure code.
//   Usable both as a bench helper and as an on-chip self-check monitor.
// Ports
//   wb_clk_i, wb_rst_i   clock, async active-high reset
//   cfg_en               arm (rising edge starts a run, low aborts to idle)
//   cfg_strict           prefixed unexpected value fails the run
//   cfg_num              checkpoints in use, 1..NUM_CHK
//   cfg_tmo              per-step timeout in cycles, 0 disables
//   cfg_chk_vec          expected values, checkpoint 0 in the LSBs
//   checkbits_i          asynchronous pad bits
//   mon_busy             run in progress
//   mon_started          checkpoint 0 matched this run (sticky)
//   mon_step             checkpoints matched so far
//   step_pulse           one-cycle pulse per match
//   mon_pass / mon_fail  sticky result flags
//   mon_fail_code        01 timeout, 10 out-of-order, 11 bad cfg_num
module checkpoint_seq_monitor #(
    parameter int              CHK_W      = 16,
    parameter int              NUM_CHK    = 4,
    parameter int              TMO_W      = 24,
    parameter int              STABLE_CYC = 3,
    parameter int              PFX_W      = 8,
    parameter logic [PFX_W-1:0] PREFIX    = 8'hAB
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       cfg_en,
    input  logic                       cfg_strict,
    input  logic [$clog2(NUM_CHK):0]   cfg_num,
    input  logic [TMO_W-1:0]           cfg_tmo,
    input  logic [NUM_CHK*CHK_W-1:0]   cfg_chk_vec,
    input  logic [CHK_W-1:0]           checkbits_i,
    output logic                       mon_busy,
    output logic                       mon_started,
    output logic [$clog2(NUM_CHK):0]   mon_step,
    output logic                       step_pulse,
    output logic                       mon_pass,
    output logic                       mon_fail,
    output logic [1:0]                 mon_fail_code
);
    localparam int SW = $clog2(NUM_CHK) + 1;
    localparam int CW = $clog2(STABLE_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PASS, S_FAIL} state_t;

    // ---------------- input path: synchroniser + stability filter ----------
    logic [CHK_W-1:0] r_sync1, r_sync2, r_cand, r_qval;
    logic [CW-1:0]    r_fcnt;
    logic             r_qload, r_qvalid;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_cand   <= '0;
            r_fcnt   <= '0;
            r_qval   <= '0;
            r_qload  <= 1'b0;
            r_qvalid <= 1'b0;
        end else begin
            r_sync1  <= checkbits_i;
            r_sync2  <= r_sync1;
            r_qvalid <= 1'b0;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_fcnt <= CW'(1);
            end else if (r_fcnt != CW'(STABLE_CYC)) begin
                r_fcnt <= r_fcnt + CW'(1);
            end
            // Load one edge after the candidate qualifies; only a new value
            // produces a q_valid pulse, so a held value never re-matches.
            if (r_fcnt == CW'(STABLE_CYC) && (!r_qload || r_cand != r_qval)) begin
                r_qval   <= r_cand;
                r_qload  <= 1'b1;
                r_qvalid <= 1'b1;
            end
        end
    end

    // ---------------- sequencer ---------------------------------------------
    state_t                          r_state;
    logic                            r_en_d, r_strict;
    logic [SW-1:0]                   r_num, r_step;
    logic [TMO_W-1:0]                r_tmo, r_tcnt;
    logic [NUM_CHK-1:0][CHK_W-1:0]   r_chk;
    logic [CHK_W-1:0]                r_last;
    logic                            r_busy, r_started, r_pulse, r_pass, r_fail;
    logic [1:0]                      r_code;

    logic [CHK_W-1:0] w_exp;
    logic             w_match, w_pfx, w_rise, w_badnum, w_repeat;

    always_comb begin
        w_exp = '0;
        for (int i = 0; i < NUM_CHK; i++)
            if (r_step == SW'(i)) w_exp = r_chk[i];
    end

    assign w_match  = r_qvalid && (r_qval == w_exp);
    assign w_pfx    = (r_qval[CHK_W-1 -: PFX_W] == PREFIX);
    assign w_rise   = cfg_en && !r_en_d;
    assign w_badnum = (cfg_num == '0) || (cfg_num > SW'(NUM_CHK));
    // Re-appearance of the last matched checkpoint is tolerated in strict mode.
    assign w_repeat = (r_step != '0) && (r_qval == r_last);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_en_d    <= 1'b0;
            r_strict  <= 1'b0;
            r_num     <= '0;
            r_tmo     <= '0;
            r_chk     <= '0;
            r_last    <= '0;
            r_step    <= '0;
            r_tcnt    <= '0;
            r_busy    <= 1'b0;
            r_started <= 1'b0;
            r_pulse   <= 1'b0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_code    <= 2'b00;
        end else begin
            r_en_d  <= cfg_en;
            r_pulse <= 1'b0;
            if (!cfg_en) begin
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_started <= 1'b0;
                r_step    <= '0;
                r_tcnt    <= '0;
                r_pass    <= 1'b0;
                r_fail    <= 1'b0;
                r_code    <= 2'b00;
            end else begin
                case (r_state)
                    S_IDLE: if (w_rise) begin
                        r_strict  <= cfg_strict;
                        r_num     <= cfg_num;
                        r_tmo     <= cfg_tmo;
                        r_chk     <= cfg_chk_vec;
                        r_step    <= '0;
                        r_started <= 1'b0;
                        r_tcnt    <= '0;
                        if (w_badnum) begin
                            r_state <= S_FAIL;
                            r_fail  <= 1'b1;
                            r_code  <= 2'b11;
                        end else begin
                            r_state <= S_WAIT;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_WAIT: begin
                        // Match outranks both out-of-order and timeout.
                        if (w_match) begin
                            r_pulse <= 1'b1;
                            r_step  <= r_step + SW'(1);
                            r_tcnt  <= '0;
                            r_last  <= r_qval;
                            if (r_step == '0) r_started <= 1'b1;
                            if (r_step + SW'(1) == r_num) begin
                                r_state <= S_PASS;
                                r_busy  <= 1'b0;
                                r_pass  <= 1'b1;
                            end
                        end else if (r_strict && r_qvalid && w_pfx && !w_repeat) begin
                            r_state <= S_FAIL;
                            r_busy  <= 1'b0;
                            r_fail  <= 1'b1;
                            r_code  <= 2'b10;
                        end else if (r_tmo != '0) begin
                            if (r_tcnt == r_tmo - TMO_W'(1)) begin
                                r_state <= S_FAIL;
                                r_busy  <= 1'b0;
                                r_fail  <= 1'b1;
                                r_code  <= 2'b01;
                            end else begin
                                r_tcnt <= r_tcnt + TMO_W'(1);
                            end
                        end
                    end
                    default: ; // PASS/FAIL hold until cfg_en drops
                endcase
            end
        end
    end

    assign mon_busy      = r_busy;
    assign mon_started   = r_started;
    assign mon_step      = r_step;
    assign step_pulse    = r_pulse;
    assign mon_pass      = r_pass;
    assign mon_fail      = r_fail;
    assign mon_fail_code = r_code;
endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
module tb_checkpoint_seq_monitor;
    localparam int CHK_W = 16, NUM_CHK = 4, TMO_W = 24, STABLE_CYC = 3;
    // Pad driven just before edge E0; pulse rises at E0+3+STABLE_CYC and is
    // first seen at the falling edge after it.
    localparam int LAT_NEG = STABLE_CYC + 4;

    logic                     clk, rst;
    logic                     cfg_en, cfg_strict;
    logic [2:0]               cfg_num;
    logic [TMO_W-1:0]         cfg_tmo;
    logic [NUM_CHK*CHK_W-1:0] cfg_chk_vec;
    logic [CHK_W-1:0]         checkbits_i;
    logic                     mon_busy, mon_started, step_pulse, mon_pass, mon_fail;
    logic [2:0]               mon_step;
    logic [1:0]               mon_fail_code;

    checkpoint_seq_monitor #(.CHK_W(CHK_W), .NUM_CHK(NUM_CHK), .TMO_W(TMO_W),
                             .STABLE_CYC(STABLE_CYC), .PFX_W(8), .PREFIX(8'hAB)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .cfg_en(cfg_en), .cfg_strict(cfg_strict),
        .cfg_num(cfg_num), .cfg_tmo(cfg_tmo), .cfg_chk_vec(cfg_chk_vec),
        .checkbits_i(checkbits_i), .mon_busy(mon_busy), .mon_started(mon_started),
        .mon_step(mon_step), .step_pulse(step_pulse), .mon_pass(mon_pass),
        .mon_fail(mon_fail), .mon_fail_code(mon_fail_code));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct { logic [2:0] step; logic started; } exp_t;
    exp_t sb[$];
    int checks = 0, failures = 0;

    task automatic push_exp(input logic [2:0] step, input logic started);
        exp_t e;
        e.step = step; e.started = started;
        sb.push_back(e);
    endtask

    task automatic settle();
        cfg_en = 1'b0;
        checkbits_i = '0;
        repeat (10) @(negedge clk);
    endtask

    task automatic arm(input logic [2:0] num, input logic strict,
                       input logic [TMO_W-1:0] tmo, input logic [63:0] chk);
        cfg_num = num; cfg_strict = strict; cfg_tmo = tmo; cfg_chk_vec = chk;
        cfg_en = 1'b1;
        @(negedge clk);
    endtask

    // Waits for the next step_pulse and scores it against the queue head.
    task automatic wait_pulse(input string name, input int budget, output int lat);
        exp_t e;
        bit seen;
        seen = 1'b0;
        lat = 0;
        for (int k = 1; k <= budget && !seen; k++) begin
            @(negedge clk);
            if (step_pulse) begin seen = 1'b1; lat = k; end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s: no step_pulse within %0d cycles", name, budget);
        end else if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: step_pulse with nothing expected", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if (mon_step !== e.step || mon_started !== e.started) begin
                failures++;
                $display("FAIL %s: step=%0d started=%0b, want step=%0d started=%0b",
                         name, mon_step, mon_started, e.step, e.started);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_en = 1'b0; cfg_strict = 1'b0; cfg_num = '0; cfg_tmo = '0;
        cfg_chk_vec = '0; checkbits_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mon_busy, mon_started, mon_step, step_pulse, mon_pass, mon_fail, mon_fail_code} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {mon_busy, mon_started, mon_step, step_pulse, mon_pass, mon_fail, mon_fail_code});
        end
        rst = 1'b0;
        settle();
        checks++;
        if (mon_busy !== 1'b0 || mon_step !== 3'd0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b step=%0d want 0/0", mon_busy, mon_step);
        end
    endtask

    task automatic test_sequence_pass();
        int lat;
        settle();
        arm(3'd2, 1'b0, 24'd1000, {16'h0, 16'h0, 16'hAB61, 16'hAB60});
        // config is latched at the arming edge; these must be ignored
        cfg_num = 3'd1; cfg_chk_vec = '1;
        checks++;
        if (mon_busy !== 1'b1 || mon_step !== 3'd0 || mon_started !== 1'b0) begin
            failures++;
            $display("FAIL seq_armed: busy=%b step=%0d started=%b want 1/0/0",
                     mon_busy, mon_step, mon_started);
        end
        push_exp(3'd1, 1'b1);
        checkbits_i = 16'hAB60;
        wait_pulse("seq_step1", 30, lat);
        checks++;
        if (mon_pass !== 1'b0) begin
            failures++;
            $display("FAIL seq_not_yet_pass: pass=%b want 0", mon_pass);
        end
        repeat (5) @(negedge clk);
        push_exp(3'd2, 1'b1);
        checkbits_i = 16'hAB61;
        wait_pulse("seq_step2", 30, lat);
        checks++;
        if (mon_pass !== 1'b1 || mon_fail !== 1'b0 || mon_busy !== 1'b0 || mon_fail_code !== 2'b00) begin
            failures++;
            $display("FAIL seq_pass: pass=%b fail=%b busy=%b code=%b want 1/0/0/00",
                     mon_pass, mon_fail, mon_busy, mon_fail_code);
        end
        cfg_en = 1'b0;
        @(negedge clk);
        checks++;
        if (mon_pass !== 1'b0 || mon_step !== 3'd0 || mon_started !== 1'b0) begin
            failures++;
            $display("FAIL seq_disarm_clear: pass=%b step=%0d started=%b want 0/0/0",
                     mon_pass, mon_step, mon_started);
        end
    endtask

    task automatic test_glitch_latency();
        int lat, npulse;
        settle();
        arm(3'd1, 1'b0, 24'd1000, {48'h0, 16'hAB60});
        checkbits_i = 16'hAB60;
        repeat (2) @(negedge clk);
        checkbits_i = 16'h0000;
        npulse = 0;
        repeat (14) begin
            @(negedge clk);
            if (step_pulse) npulse++;
        end
        checks++;
        if (npulse !== 0 || mon_step !== 3'd0) begin
            failures++;
            $display("FAIL glitch_filtered: pulses=%0d step=%0d want 0/0", npulse, mon_step);
        end
        push_exp(3'd1, 1'b1);
        checkbits_i = 16'hAB60;
        wait_pulse("glitch_steady", 30, lat);
        checks++;
        if (lat !== LAT_NEG) begin
            failures++;
            $display("FAIL latency: pulse at negedge %0d want %0d", lat, LAT_NEG);
        end
        checks++;
        if (mon_pass !== 1'b1) begin
            failures++;
            $display("FAIL single_chk_pass: pass=%b want 1", mon_pass);
        end
    endtask

    task automatic test_timeout();
        int lat, n;
        settle();
        arm(3'd2, 1'b0, 24'd50, {32'h0, 16'hAB61, 16'hAB60});
        push_exp(3'd1, 1'b1);
        checkbits_i = 16'hAB60;
        wait_pulse("tmo_step1", 30, lat);
        n = 0;
        while (!mon_fail && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 50) begin
            failures++;
            $display("FAIL tmo_delay: fail after %0d cycles want 50", n);
        end
        checks++;
        if (mon_fail_code !== 2'b01 || mon_step !== 3'd1 || mon_busy !== 1'b0) begin
            failures++;
            $display("FAIL tmo_state: code=%b step=%0d busy=%b want 01/1/0",
                     mon_fail_code, mon_step, mon_busy);
        end
    endtask

    task automatic test_strict_order();
        int lat, n;
        settle();
        arm(3'd3, 1'b1, 24'd1000, {16'h0, 16'hAB62, 16'hAB61, 16'hAB60});
        push_exp(3'd1, 1'b1);
        checkbits_i = 16'hAB60;
        wait_pulse("strict_step1", 30, lat);
        checkbits_i = 16'hAB62;
        n = 0;
        while (!mon_fail && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (mon_fail !== 1'b1 || mon_fail_code !== 2'b10 || mon_step !== 3'd1) begin
            failures++;
            $display("FAIL strict_ooo: fail=%b code=%b step=%0d want 1/10/1",
                     mon_fail, mon_fail_code, mon_step);
        end
        settle();
        arm(3'd3, 1'b0, 24'd1000, {16'h0, 16'hAB62, 16'hAB61, 16'hAB60});
        push_exp(3'd1, 1'b1);
        checkbits_i = 16'hAB60;
        wait_pulse("lax_step1", 30, lat);
        checkbits_i = 16'hAB62;
        repeat (20) @(negedge clk);
        checks++;
        if (mon_fail !== 1'b0 || mon_busy !== 1'b1 || mon_step !== 3'd1) begin
            failures++;
            $display("FAIL lax_ignore: fail=%b busy=%b step=%0d want 0/1/1",
                     mon_fail, mon_busy, mon_step);
        end
        n = 0;
        while (!mon_fail && n < 1100) begin @(negedge clk); n++; end
        checks++;
        if (mon_fail !== 1'b1 || mon_fail_code !== 2'b01) begin
            failures++;
            $display("FAIL lax_timeout: fail=%b code=%b want 1/01", mon_fail, mon_fail_code);
        end
    endtask

    task automatic test_bad_config();
        logic [2:0] nums [2];
        bit busy_seen;
        nums[0] = 3'd0; nums[1] = 3'd5;
        for (int i = 0; i < 2; i++) begin
            settle();
            busy_seen = 1'b0;
            arm(nums[i], 1'b0, 24'd1000, {16'h0, 16'hAB62, 16'hAB61, 16'hAB60});
            checks++;
            if (mon_fail !== 1'b1 || mon_fail_code !== 2'b11) begin
                failures++;
                $display("FAIL bad_cfg_%0d: fail=%b code=%b want 1/11", nums[i], mon_fail, mon_fail_code);
            end
            repeat (3) begin
                if (mon_busy) busy_seen = 1'b1;
                @(negedge clk);
            end
            checks++;
            if (busy_seen !== 1'b0) begin
                failures++;
                $display("FAIL bad_cfg_busy_%0d: busy seen=%b want 0", nums[i], busy_seen);
            end
        end
    endtask

    task automatic test_abort_reset();
        int lat;
        settle();
        arm(3'd2, 1'b0, 24'd1000, {32'h0, 16'hAB61, 16'hAB60});
        push_exp(3'd1, 1'b1);
        checkbits_i = 16'hAB60;
        wait_pulse("abort_step1", 30, lat);
        cfg_en = 1'b0;
        @(negedge clk);
        checks++;
        if (mon_step !== 3'd0 || mon_started !== 1'b0 || mon_busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_clear: step=%0d started=%b busy=%b want 0/0/0",
                     mon_step, mon_started, mon_busy);
        end
        arm(3'd2, 1'b0, 24'd1000, {32'h0, 16'hAB61, 16'hAB60});
        checks++;
        if (mon_step !== 3'd0 || mon_started !== 1'b0 || mon_busy !== 1'b1) begin
            failures++;
            $display("FAIL rearm: step=%0d started=%b busy=%b want 0/0/1",
                     mon_step, mon_started, mon_busy);
        end
        checkbits_i = 16'h0000;
        repeat (8) @(negedge clk);
        push_exp(3'd1, 1'b1);
        checkbits_i = 16'hAB60;
        wait_pulse("rearm_step1", 30, lat);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mon_busy, mon_started, mon_step, step_pulse, mon_pass, mon_fail, mon_fail_code} !== '0) begin
            failures++;
            $display("FAIL async_reset: got %b want all zero",
                     {mon_busy, mon_started, mon_step, step_pulse, mon_pass, mon_fail, mon_fail_code});
        end
        @(negedge clk);
        rst = 1'b0;
        cfg_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence_pass();
        test_glitch_latency();
        test_timeout();
        test_strict_order();
        test_bad_config();
        test_abort_reset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expected pulses never seen", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
